// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Execute-stage load/store unit. Handles byte/half/word accesses
//            with sign/zero extension, store lane steering and alignment
//            checking, and runs one access at a time over a registered
//            valid/ready data-memory bus.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W      request/bus address width (data width fixed at 32)
// Ports
//   clk, rst    clock, synchronous active-high reset
//   req_*       execute-stage request (held stable until req_ready)
//   req_ready   one-cycle completion pulse; rdata/fault valid with it
//   rdata       extended load result (0 for stores and faults)
//   fault       illegal funct3 or unsupported misalignment
//   busy        unit not idle (execute holds its pipeline)
//   mem_*       word-aligned data-memory bus, one access in flight
// Configuration
//   LSU_MISALIGN_SPLIT_EN  when defined, misaligned accesses are served
//                          (split into two beats when they cross a word);
//                          when undefined, every misaligned access faults.
// ============================================================================
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         beat0_q, beat0_d;
  logic                req_ready_q, req_ready_d;
  logic                fault_q, fault_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;

  // In IDLE the request is decoded straight from the inputs so the first
  // beat can be registered at the accept edge; afterwards the latched copy.
  logic                w_store;
  logic [2:0]          w_funct3;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;
  logic [1:0]          w_off;
  logic [1:0]          w_size;
  logic                w_legal;
  logic                w_split;
  logic                w_bad;
  logic [31:0]         w_rep;
  logic [31:0]         w_rot;
  logic [3:0]          w_strb_base;
  logic [7:0]          w_strb64;
  logic [5:0]          w_shamt;
  logic [ADDR_W-1:0]   w_word0;
  logic [ADDR_W-1:0]   w_word1;

  // Select the addressed byte/half (possibly straddling into the next word)
  // and extend it according to funct3.
  function automatic logic [31:0] extract(input logic [63:0] pair,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (f3)
      3'd0:    extract = {{24{sh[7]}}, sh[7:0]};
      3'd1:    extract = {{16{sh[15]}}, sh[15:0]};
      3'd4:    extract = {24'h0, sh[7:0]};
      3'd5:    extract = {16'h0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    w_store  = (state_q == IDLE) ? req_store  : store_q;
    w_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    w_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    w_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
    w_off    = w_addr[1:0];
    w_size   = w_funct3[1:0];

    case (w_funct3)
      3'd0, 3'd1, 3'd2: w_legal = 1'b1;
      3'd4, 3'd5:       w_legal = !w_store;
      default:          w_legal = 1'b0;
    endcase

`ifdef LSU_MISALIGN_SPLIT_EN
    // off + size beyond 4 bytes crosses into the next word.
    case (w_size)
      2'd0:    w_split = 1'b0;
      2'd1:    w_split = (w_off == 2'd3);
      default: w_split = (w_off != 2'd0);
    endcase
    w_bad = !w_legal;
`else
    w_split = 1'b0;
    w_bad   = !w_legal ||
              ((w_size == 2'd1) && w_off[0]) ||
              ((w_size == 2'd2) && (w_off != 2'd0));
`endif

    case (w_size)
      2'd0:    begin w_rep = {4{w_wdata[7:0]}};  w_strb_base = 4'b0001; end
      2'd1:    begin w_rep = {2{w_wdata[15:0]}}; w_strb_base = 4'b0011; end
      default: begin w_rep = w_wdata;            w_strb_base = 4'b1111; end
    endcase

    // Rotating the replicated data places every byte on its lane for both
    // beats of a split access and leaves aligned patterns unchanged.
    w_shamt  = {1'b0, w_off, 3'b000};
    w_rot    = (w_rep << w_shamt) | (w_rep >> (6'd32 - w_shamt));
    w_strb64 = {4'b0000, w_strb_base} << w_off;
    w_word0  = {w_addr[ADDR_W-1:2], 2'b00};
    w_word1  = w_word0 + ADDR_W'(4);
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat0_d     = beat0_q;
    req_ready_d = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = '0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (w_bad) begin
            state_d     = RESP;
            req_ready_d = 1'b1;
            fault_d     = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = w_word0;
            mem_wdata_d = w_store ? w_rot : 32'h0;
            mem_wstrb_d = w_store ? w_strb64[3:0] : 4'b0000;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          beat0_d = mem_rdata;
          if (w_split) begin
            state_d     = BEAT1;
            mem_addr_d  = w_word1;
            mem_wstrb_d = w_store ? w_strb64[7:4] : 4'b0000;
          end else begin
            state_d     = RESP;
            req_ready_d = 1'b1;
            rdata_d     = w_store ? 32'h0 : extract({32'h0, mem_rdata}, w_off, w_funct3);
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d     = RESP;
          req_ready_d = 1'b1;
          rdata_d     = w_store ? 32'h0 : extract({mem_rdata, beat0_q}, w_off, w_funct3);
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat0_q     <= '0;
      req_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat0_q     <= beat0_d;
      req_ready_q <= req_ready_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign busy      = (state_q != IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
`default_nettype wire
